dm_cache_ctrl: RTL and testbench
================================

Name: dm_cache_ctrl

Overview:
- Controller FSM for the direct-mapped, write-back, write-allocate data cache in the single-cycle MIPS core.
- Sits between the CPU load/store port, the cache tag array (32 × 24 b), the cache data array (32 × 256 b) and the line-wide data memory (512 × 256 b).
- Sequences hit/miss detection, dirty-line write-back and line refill.
- Stalls the core while a miss is serviced.

Parameters:
- INDEX_W, 5, line index bits (32 lines).
- TAG_W, 22, stored tag bits; tag entry = {valid, dirty, tag} = TAG_W+2 = 24 b.
- LINE_W, 256, line width (8 × 32-bit words).
- MEM_AW, 9, memory line-address width (512 lines).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  load/store request valid.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address: tag = [31:10], index = [9:5], word = [4:2].
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data.
- cpu_ready  out  1  access completes this cycle.
- stall  out  1  freeze PC/pipeline.
- tag_idx  out  INDEX_W  tag array index.
- tag_rdata  in  24  combinational tag read.
- tag_we  out  1  tag write strobe.
- tag_wdata  out  24  tag write value.
- data_idx  out  INDEX_W  data array index.
- data_rdata  in  LINE_W  combinational line read.
- data_we  out  1  data write strobe.
- data_wdata  out  LINE_W  data write value.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write-back, 0 = refill read.
- mem_addr  out  MEM_AW  memory line address.
- mem_wdata  out  LINE_W  victim line.
- mem_rdata  in  LINE_W  refill line.
- mem_ack  in  1  one-cycle completion pulse.

Behaviour:
- States: COMPARE, WRITEBACK, ALLOCATE. Reset state is COMPARE.
- Reset values: all strobes 0, stall = 0, cpu_ready = 0, cpu_rdata = 0.
- tag_idx = data_idx = cpu_addr[9:5] at all times.
- hit = tag_rdata[23] & (tag_rdata[21:0] == cpu_addr[31:10]).
- COMPARE, no cpu_req: idle; stall = 0, cpu_ready = 0.
- COMPARE, cpu_req & hit:
  - cpu_ready = 1 and stall = 0, combinational, zero added latency.
  - Load: cpu_rdata = data_rdata[32w+31:32w] with w = cpu_addr[4:2].
  - Store: data_we = 1; data_wdata = data_rdata with word w replaced by cpu_wdata; tag_we = 1 with tag_wdata = {1, 1, tag} (dirty set). Arrays written at the clock edge.
- COMPARE, cpu_req & miss:
  - stall = 1, cpu_ready = 0.
  - Next state WRITEBACK if valid & dirty (tag_rdata[23:22] == 2'b11), else ALLOCATE.
- WRITEBACK:
  - mem_req = 1, mem_we = 1, mem_addr = {tag_rdata[3:0], index}, mem_wdata = data_rdata; stall = 1.
  - Hold until mem_ack, then go to ALLOCATE.
- ALLOCATE:
  - mem_req = 1, mem_we = 0, mem_addr = {cpu_addr[13:10], index}; stall = 1.
  - On mem_ack: data_we = 1 with data_wdata = mem_rdata; tag_we = 1 with tag_wdata = {1, 0, cpu_addr[31:10]}. Next state COMPARE.
- COMPARE then re-evaluates and hits, so a miss costs 1 + write-back cycles + refill cycles before cpu_ready.
- mem_req stays high continuously from entering WRITEBACK/ALLOCATE until the ack cycle inclusive. It drops in the cycle after ack.
- The CPU holds cpu_addr, cpu_we and cpu_wdata stable while stall = 1. If cpu_req drops mid-miss, the refill still completes and the FSM returns to COMPARE.
- mem_ack outside WRITEBACK/ALLOCATE is ignored.
- Tag bits above memory size are truncated in mem_addr; aliasing is the software's problem.
- Reset asserted mid-miss: FSM returns to COMPARE immediately and all strobes drop. Array contents are not touched (the bench clears them).

Optional Feature:
- Macro: DM_CACHE_STATS_EN.
- When defined:
  - Extra output ports hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments on every cpu_ready cycle that was a first-try hit; a retry hit following a refill is not counted.
  - miss_cnt increments on each COMPARE→WRITEBACK/ALLOCATE transition.
  - Both counters reset to 0 and wrap at 2^32.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold load: zeroed tags, memory line 1 word 2 = 0xFFFFFFFF, load addr 0x28 → stall, ALLOCATE, ack after 3 cycles, then cpu_ready with cpu_rdata = 0xFFFFFFFF. Tag[1] = {1, 0, 0}.
- Store hit: after the above, store 0x1234 to 0x2C → cpu_ready in the same cycle, no stall. Tag[1] dirty = 1, data[1][127:96] = 0x1234.
- Dirty eviction: load 0x428 (same index, tag 1) → WRITEBACK with mem_addr = 1 and mem_wdata[127:96] = 0x1234, then ALLOCATE with mem_addr = 0x21. Final tag[1] = {1, 0, 1}.
- Clean miss: load 0x40 to an index with a valid clean line → no WRITEBACK; mem_we stays 0 throughout.
- Reset mid-refill: drive rst low while in ALLOCATE before ack → mem_req, stall, tag_we and data_we go 0 asynchronously. After release, the FSM is in COMPARE.
- Stats (DM_CACHE_STATS_EN): the above sequence yields hit_cnt = 1 and miss_cnt = 3.

Source files
------------

// File: rtl/dm_cache_ctrl.sv
// Controller FSM for a direct-mapped, write-back, write-allocate data cache.
// Optional hit/miss counters are compiled in with `define DM_CACHE_STATS_EN.
module dm_cache_ctrl #(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 22,
  parameter int LINE_W  = 256,
  parameter int MEM_AW  = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_ready,
  output logic                 stall,
  output logic [INDEX_W-1:0]   tag_idx,
  input  logic [TAG_W+1:0]     tag_rdata,
  output logic                 tag_we,
  output logic [TAG_W+1:0]     tag_wdata,
  output logic [INDEX_W-1:0]   data_idx,
  input  logic [LINE_W-1:0]    data_rdata,
  output logic                 data_we,
  output logic [LINE_W-1:0]    data_wdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [MEM_AW-1:0]    mem_addr,
  output logic [LINE_W-1:0]    mem_wdata,
  input  logic [LINE_W-1:0]    mem_rdata,
  input  logic                 mem_ack
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
`endif
);

  localparam int WORD_W   = $clog2(LINE_W / 32);
  localparam int OFF_W    = WORD_W + 2;
  localparam int TAGLSB_W = MEM_AW - INDEX_W;

  typedef enum logic [1:0] {
    S_COMPARE   = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic [WORD_W-1:0]  w_word;
  logic               w_valid;
  logic               w_dirty;
  logic               w_hit;
  logic [LINE_W-1:0]  w_merged;
  logic               w_unused_bits;

  assign w_index       = cpu_addr[OFF_W +: INDEX_W];
  assign w_tag         = cpu_addr[OFF_W + INDEX_W +: TAG_W];
  assign w_word        = cpu_addr[2 +: WORD_W];
  assign w_valid       = tag_rdata[TAG_W+1];
  assign w_dirty       = tag_rdata[TAG_W];
  assign w_hit         = w_valid && (tag_rdata[TAG_W-1:0] == w_tag);
  assign w_unused_bits = ^cpu_addr[1:0];

  assign tag_idx  = w_index;
  assign data_idx = w_index;

  always_comb begin
    w_merged = data_rdata;
    w_merged[32 * int'(w_word) +: 32] = cpu_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_COMPARE;
    else      r_state <= w_state_nxt;
  end

  // Every output is gated by rst so strobes drop the instant reset asserts.
  always_comb begin
    w_state_nxt = r_state;
    cpu_rdata   = '0;
    cpu_ready   = 1'b0;
    stall       = 1'b0;
    tag_we      = 1'b0;
    tag_wdata   = '0;
    data_we     = 1'b0;
    data_wdata  = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (rst) begin
      unique case (r_state)
        S_COMPARE: begin
          if (cpu_req) begin
            if (w_hit) begin
              cpu_ready = 1'b1;
              if (cpu_we) begin
                data_we    = 1'b1;
                data_wdata = w_merged;
                tag_we     = 1'b1;
                tag_wdata  = {1'b1, 1'b1, w_tag};
              end else begin
                cpu_rdata = data_rdata[32 * int'(w_word) +: 32];
              end
            end else begin
              stall       = 1'b1;
              w_state_nxt = (w_valid && w_dirty) ? S_WRITEBACK : S_ALLOCATE;
            end
          end
        end
        S_WRITEBACK: begin
          stall     = 1'b1;
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {tag_rdata[TAGLSB_W-1:0], w_index};
          mem_wdata = data_rdata;
          if (mem_ack) w_state_nxt = S_ALLOCATE;
        end
        S_ALLOCATE: begin
          stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = {w_tag[TAGLSB_W-1:0], w_index};
          if (mem_ack) begin
            data_we     = 1'b1;
            data_wdata  = mem_rdata;
            tag_we      = 1'b1;
            tag_wdata   = {1'b1, 1'b0, w_tag};
            w_state_nxt = S_COMPARE;
          end
        end
        default: w_state_nxt = S_COMPARE;
      endcase
    end
  end

`ifdef DM_CACHE_STATS_EN
  // r_retry marks the COMPARE cycle right after a refill so its hit is not counted.
  logic r_retry;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retry  <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      r_retry <= (r_state == S_ALLOCATE) && mem_ack;
      if (cpu_ready && !r_retry) hit_cnt <= hit_cnt + 32'd1;
      if ((r_state == S_COMPARE) && (w_state_nxt != S_COMPARE)) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: behavioural tag/data/memory arrays, directed table,
// reset-mid-refill sequence and a randomized run against an abstract cache model.
module tb_dm_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic         stall;
  logic [4:0]   tag_idx;
  logic [23:0]  tag_rdata;
  logic         tag_we;
  logic [23:0]  tag_wdata;
  logic [4:0]   data_idx;
  logic [255:0] data_rdata;
  logic         data_we;
  logic [255:0] data_wdata;
  logic         mem_req;
  logic         mem_we;
  logic [8:0]   mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_ack = 1'b0;
`ifdef DM_CACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  dm_cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .stall(stall),
    .tag_idx(tag_idx), .tag_rdata(tag_rdata), .tag_we(tag_we), .tag_wdata(tag_wdata),
    .data_idx(data_idx), .data_rdata(data_rdata), .data_we(data_we), .data_wdata(data_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DM_CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [23:0]  tag_arr  [32];
  logic [255:0] data_arr [32];
  logic [255:0] mem_arr  [512];

  assign tag_rdata  = tag_arr[tag_idx];
  assign data_rdata = data_arr[data_idx];
  assign mem_rdata  = mem_arr[mem_addr];

  int total = 0;
  int bad   = 0;

  // memory responder state and per-access observations
  int           lat = 1;
  int           cnt = 0;
  logic         s_stall, s_ready, s_mem_req;
  logic [31:0]  s_rdata;
  bit           seen_wb, seen_rd;
  logic [8:0]   wb_addr, rd_addr;
  logic [255:0] wb_line;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge, commit array writes and the ack 1 unit after posedge.
  task automatic tick();
    logic         t_tw, t_dw, t_mw, nack;
    logic [4:0]   t_ti, t_di;
    logic [23:0]  t_twd;
    logic [255:0] t_dwd, t_mwd;
    logic [8:0]   t_ma;
    @(negedge clk);
    s_stall = stall; s_ready = cpu_ready; s_rdata = cpu_rdata; s_mem_req = mem_req;
    t_tw = tag_we;  t_ti = tag_idx;  t_twd = tag_wdata;
    t_dw = data_we; t_di = data_idx; t_dwd = data_wdata;
    t_mw = mem_req & mem_we & mem_ack; t_ma = mem_addr; t_mwd = mem_wdata;
    if (mem_we && !seen_wb) begin seen_wb = 1; wb_addr = mem_addr; wb_line = mem_wdata; end
    if (mem_req && !mem_we && !seen_rd) begin seen_rd = 1; rd_addr = mem_addr; end
    nack = 1'b0;
    if (mem_ack) cnt = 0;
    else if (mem_req) begin
      if (cnt >= lat - 1) nack = 1'b1;
      else cnt++;
    end
    @(posedge clk);
    #1;
    if (t_tw) tag_arr[t_ti] = t_twd;
    if (t_dw) data_arr[t_di] = t_dwd;
    if (t_mw) mem_arr[t_ma] = t_mwd;
    mem_ack = nack;
  endtask

  task automatic access(input logic [31:0] addr, input bit we, input logic [31:0] wd, input int l,
                        output logic [31:0] rd, output int stalls, output bit ok);
    cpu_addr = addr; cpu_we = we; cpu_wdata = wd; cpu_req = 1'b1;
    lat = l; stalls = 0; ok = 0; rd = '0;
    seen_wb = 0; seen_rd = 0; wb_addr = '0; rd_addr = '0; wb_line = '0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (s_ready) begin rd = s_rdata; ok = 1; break; end
      if (s_stall) stalls++;
    end
    cpu_req = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [31:0] wd;
    int          lat;
    logic [31:0] exp_rd;
    int          exp_stalls;
    bit          exp_wb;
    logic [8:0]  exp_wb_addr;
    bit          exp_refill;
    logic [8:0]  exp_rd_addr;
    logic [23:0] exp_tag;
  } vec_t;

  vec_t vt [4];

  // abstract model for the random phase
  logic [31:0] ref_mem [4096];
  bit          rv [32];
  bit          rdty [32];
  logic [3:0]  rt [32];

  initial begin
    logic [31:0] rd;
    int          st;
    bit          ok;

    vt[0] = '{32'h28,  1'b0, 32'h0,    3, 32'hFFFF_FFFF, 5, 1'b0, 9'd0, 1'b1, 9'd1,   24'h800000};
    vt[1] = '{32'h2C,  1'b1, 32'h1234, 3, 32'h0,         0, 1'b0, 9'd0, 1'b0, 9'd0,   24'hC00000};
    vt[2] = '{32'h428, 1'b0, 32'h0,    3, 32'hA5A5_0001, 9, 1'b1, 9'd1, 1'b1, 9'h21,  24'h800001};
    vt[3] = '{32'h40,  1'b0, 32'h0,    3, 32'h0BAD_CAFE, 5, 1'b0, 9'd0, 1'b1, 9'd2,   24'h800000};

    for (int i = 0; i < 32; i++) begin tag_arr[i] = '0; data_arr[i] = '0; end
    for (int i = 0; i < 512; i++) mem_arr[i] = '0;
    mem_arr[1][95:64]    = 32'hFFFF_FFFF;
    mem_arr[9'h21][95:64] = 32'hA5A5_0001;
    mem_arr[2][31:0]     = 32'h0BAD_CAFE;
    tag_arr[2] = 24'h800005;
    tag_arr[0] = 24'hC00000;

    // reset held with a store that would hit index 0: everything must stay quiet
    cpu_addr = 32'h0; cpu_we = 1'b1; cpu_wdata = 32'hDEAD; cpu_req = 1'b1;
    #2;
    chk("reset_outputs", {stall, cpu_ready, mem_req, tag_we, data_we, cpu_rdata}, '0);
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    rst = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      access(vt[i].addr, vt[i].we, vt[i].wd, vt[i].lat, rd, st, ok);
      chk($sformatf("v%0d_ready", i), ok, 1'b1);
      if (!vt[i].we) chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("v%0d_stalls", i), st, vt[i].exp_stalls);
      chk($sformatf("v%0d_wb_seen", i), seen_wb, vt[i].exp_wb);
      if (vt[i].exp_wb) chk($sformatf("v%0d_wb_addr", i), wb_addr, vt[i].exp_wb_addr);
      chk($sformatf("v%0d_refill_seen", i), seen_rd, vt[i].exp_refill);
      if (vt[i].exp_refill) chk($sformatf("v%0d_refill_addr", i), rd_addr, vt[i].exp_rd_addr);
      chk($sformatf("v%0d_tag", i), tag_arr[vt[i].addr[9:5]], vt[i].exp_tag);
      if (i == 1) begin
        chk("store_word", data_arr[1][127:96], 32'h1234);
        chk("store_keeps_word2", data_arr[1][95:64], 32'hFFFF_FFFF);
      end
      if (i == 2) begin
        chk("wb_line_word3", wb_line[127:96], 32'h1234);
        chk("mem_after_wb", mem_arr[1][127:96], 32'h1234);
      end
    end
`ifdef DM_CACHE_STATS_EN
    chk("hit_cnt", hit_cnt, 32'd1);
    chk("miss_cnt", miss_cnt, 32'd3);
`endif

    // reset during a refill: strobes drop asynchronously, FSM restarts in COMPARE
    cpu_addr = 32'h1028; cpu_we = 1'b0; cpu_req = 1'b1; lat = 20; seen_rd = 0;
    tick(); tick(); tick();
    chk("rstmid_in_alloc", s_mem_req, 1'b1);
    rst = 1'b0;
    #1;
    chk("rstmid_mem_req", mem_req, 1'b0);
    chk("rstmid_stall", stall, 1'b0);
    chk("rstmid_strobes", {tag_we, data_we, cpu_ready}, 3'b0);
    mem_ack = 1'b0; cnt = 0;
    tick();
    rst = 1'b1; cpu_req = 1'b0;
    tick();
    chk("rstmid_idle", {s_stall, s_mem_req}, 2'b0);
    access(32'h428, 1'b0, 32'h0, 3, rd, st, ok);
    chk("rstmid_hit_ready", ok, 1'b1);
    chk("rstmid_hit_stalls", st, 0);
    chk("rstmid_hit_rdata", rd, 32'hA5A5_0001);

    // randomized phase from a clean cache; addresses stay below 16 KiB so no aliasing
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin tag_arr[i] = '0; rv[i] = 0; rdty[i] = 0; rt[i] = '0; end
    for (int ln = 0; ln < 512; ln++)
      for (int w = 0; w < 8; w++) begin
        ref_mem[ln*8 + w] = $urandom;
        mem_arr[ln][w*32 +: 32] = ref_mem[ln*8 + w];
      end
    tick();

    for (int n = 0; n < 300; n++) begin
      logic [3:0]  tg;
      logic [4:0]  ix;
      logic [2:0]  wd_i;
      logic [31:0] a, wv;
      bit          we_r, hit;
      int          l, exp_st;
      tg   = 4'($urandom_range(0, 3));
      ix   = 5'($urandom_range(0, 7));
      wd_i = 3'($urandom_range(0, 7));
      we_r = bit'($urandom_range(0, 1));
      wv   = $urandom;
      l    = $urandom_range(1, 4);
      a    = {18'b0, tg, ix, wd_i, 2'b00};
      hit  = rv[ix] && (rt[ix] == tg);
      exp_st = hit ? 0 : 1 + ((rv[ix] && rdty[ix]) ? l + 1 : 0) + l + 1;
      access(a, we_r, wv, l, rd, st, ok);
      chk($sformatf("rnd%0d_ready", n), ok, 1'b1);
      chk($sformatf("rnd%0d_stalls", n), st, exp_st);
      if (!hit) begin rv[ix] = 1; rt[ix] = tg; rdty[ix] = 0; end
      if (we_r) begin
        ref_mem[a[13:2]] = wv;
        rdty[ix] = 1;
      end else begin
        chk($sformatf("rnd%0d_rdata", n), rd, ref_mem[a[13:2]]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
